// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one iteration per clock).
//
// A start in IDLE captures bin. Thirty-two shift-add-3 iterations follow, then
// bcd/overflow update together with a one-cycle done pulse. Latency from the
// accepting edge to done is 33 clocks. Back-to-back starts repeat every 35 clocks.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    conversion request, accepted only when not busy
//   bin      32-bit unsigned input, captured on the accepting edge
//   busy     conversion in progress, including the done cycle
//   done     one-cycle pulse: bcd/overflow just updated
//   bcd      8 packed BCD digits, [3:0] least significant
//   overflow last captured bin exceeded OVF_LIMIT
//
// Build option: BCD_SATURATE_EN. When it is defined, an overflow result is
// 32'h9999_9999. Otherwise the overflow result is 32'hEEEE_EEEE, an error pattern
// on the display.

module bin_to_bcd_converter #(
  parameter logic [31:0] OVF_LIMIT = 32'd99_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic        busy,
  output logic        done,
  output logic [31:0] bcd,
  output logic        overflow
);

`ifdef BCD_SATURATE_EN
  localparam logic [31:0] OvfBcd = 32'h9999_9999;
`else
  localparam logic [31:0] OvfBcd = 32'hEEEE_EEEE;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] sreg_q, sreg_d;
  logic [31:0] scratch_q, scratch_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [31:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [31:0] adj;

  // Add 3 to every digit >= 5 before the shift. A carry out of digit 7 is dropped.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 8; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    scratch_d  = scratch_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // done_q is high in the cycle after DONE. That cycle still counts as busy.
        if (start && !done_q) begin
          sreg_d     = bin;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_pend_d = (bin > OVF_LIMIT);
          state_d    = StShift;
        end
      end
      StShift: begin
        scratch_d = {adj[30:0], sreg_q[31]};
        sreg_d    = {sreg_q[30:0], 1'b0};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        bcd_d   = ovf_pend_q ? OvfBcd : scratch_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sreg_q     <= '0;
      scratch_q  <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sreg_q     <= sreg_d;
      scratch_q  <= scratch_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle) || done_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule
